dvi_pixel_fetch: RTL and testbench
==================================

DVI_PIXEL_FETCH -- requirements
Module: dvi_pixel_fetch

Interface
REQ-001 Parameters SHALL be: H_ACTIVE, default 640, active pixels per line; V_ACTIVE, default 480, active lines per frame; WORDS = H_ACTIVE*V_ACTIVE/8, derived, frame-buffer words per frame.
REQ-002 H_ACTIVE*V_ACTIVE SHALL be a multiple of 8.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port frame_start, input, 1 bit: one-cycle pulse that starts a new frame.
REQ-006 Port pixel_en, input, 1 bit: consume one active-video pixel this cycle.
REQ-007 Port mem_req, output, 1 bit: frame-buffer read request.
REQ-008 Port mem_addr, output, 16 bits: word address of the read.
REQ-009 Port mem_ack, input, 1 bit: mem_rdata is valid this cycle; arrives 1 or more cycles after mem_req rises.
REQ-010 Port mem_rdata, input, 24 bits: eight 3-bit codes; pixel i is in bits [3i+2:3i].
REQ-011 Port color_code, output, 3 bits, registered: drives the color_palette input.
REQ-012 Port underflow, output, 1 bit: sticky error flag.

Function
REQ-013 The block SHALL hold a 2-entry word FIFO and a 3-bit pixel index into the head word.
REQ-014 mem_req SHALL rise only when FIFO occupancy plus outstanding requests is less than 2; at most one request SHALL be outstanding.
REQ-015 Once raised, mem_req SHALL stay high, with mem_addr stable, until the cycle mem_ack is sampled high.
REQ-016 mem_req SHALL be low in the cycle after the ack and may rise again the following cycle.
REQ-017 On each accepted ack, mem_rdata SHALL be pushed into the FIFO and mem_addr SHALL increment, wrapping from WORDS-1 to 0.
REQ-018 When pixel_en=1 and the FIFO is non-empty, color_code SHALL take the head word's pixel[index] on the next edge (latency 1 cycle).
REQ-019 In the same case, index SHALL increment; when index=7 it SHALL wrap to 0 and the head word SHALL be popped.
REQ-020 When pixel_en=0, color_code SHALL be 0 on the next edge (blanking black), and index and FIFO SHALL be unchanged.
REQ-021 Underflow case (pixel_en=1, FIFO empty): color_code SHALL be 0, underflow SHALL be set, and index SHALL NOT advance.
REQ-022 A push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-023 frame_start=1 SHALL take priority over pixel_en; on the next edge the FIFO is flushed, index=0, mem_addr=0, underflow=0 and color_code=0.
REQ-024 If a request is outstanding at frame_start, mem_req SHALL be dropped, and exactly one subsequent mem_ack SHALL be discarded (no push, no address increment).
REQ-025 New requests after frame_start SHALL start only after that discarded ack.
REQ-026 An ack arriving while mem_req is low and no discard is pending SHALL be ignored.
REQ-027 Internal states SHALL be: IDLE (no request), REQ (waiting for ack), DISCARD (waiting for stale ack).
REQ-028 State IDLE SHALL go to REQ when there is FIFO space.
REQ-029 State REQ SHALL go to IDLE on ack, or to DISCARD on frame_start.
REQ-030 State DISCARD SHALL go to IDLE on ack.

Reset
REQ-031 While rst_n=0, outputs SHALL be, asynchronously: mem_req=0, mem_addr=0, color_code=0, underflow=0; the FIFO is empty, index=0 and state is IDLE.
REQ-032 After rst_n rises, prefetch SHALL begin on the first clock edge without waiting for frame_start.
REQ-033 A reset asserted mid-request SHALL abandon the request; no ack discard SHALL be pending afterwards.

Verification
REQ-034 Prefill scenario: release reset and ack each request 1 cycle after it rises with mem_rdata=24'hFAC688. Required response: requests at addresses 0 and 1 only, then mem_req stays 0.
REQ-035 Stream scenario: after prefill, hold pixel_en high for 8 cycles starting at cycle N. Required response: color_code=0,1,...,7 on cycles N+1..N+8, and a request to address 2 follows the pop.
REQ-036 Underflow scenario: never ack and pulse pixel_en. Required response: color_code=0 and underflow=1 the next cycle; underflow stays 1 until frame_start.
REQ-037 Discard scenario: frame_start while the request to address 1 is outstanding, then ack with 24'hFFFFFF. Required response: that data is not pushed, and the next request is to address 0.
REQ-038 Wrap scenario: H_ACTIVE=16, V_ACTIVE=2 (WORDS=4), streaming continuously. Required response: addresses 0,1,2,3,0,1.
REQ-039 Async reset scenario: assert rst_n=0 mid-request, between clock edges. Required response: mem_req, mem_addr and color_code go to 0 immediately.

Source files
------------

// File: rtl/dvi_pixel_fetch.sv
// DVI pixel fetch: prefetches frame-buffer words into a 2-entry FIFO and
// unpacks eight 3-bit palette codes per word, one per active-video pixel.
//
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   frame_start           - 1-cycle pulse: flush, restart at address 0
//   pixel_en              - consume one pixel this cycle
//   mem_req, mem_addr     - read request and word address (held to ack)
//   mem_ack, mem_rdata    - read data strobe and 8 packed 3-bit codes
//   color_code            - registered palette code (0 while blanking)
//   underflow             - sticky: pixel wanted while FIFO empty
module dvi_pixel_fetch #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int WORDS    = H_ACTIVE * V_ACTIVE / 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        pixel_en,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [23:0] mem_rdata,
    output logic [2:0]  color_code,
    output logic        underflow
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t      state;
    logic [23:0] fifo_q [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [2:0]  index;

    logic [23:0] head;
    logic [4:0]  bit_lo;
    logic        have;
    logic        take;
    logic        pop;
    logic        push;
    logic [15:0] addr_next;

    assign head   = fifo_q[rd_ptr];
    assign bit_lo = {1'b0, index, 1'b0} + {2'b00, index};
    assign have   = (count != 2'd0);
    assign take   = pixel_en && have && !frame_start;
    assign pop    = take && (index == 3'd7);
    // An ack landing with frame_start belongs to the flushed frame.
    assign push   = (state == REQ) && mem_ack && !frame_start;

    assign addr_next = (mem_addr == 16'(WORDS - 1)) ?
                       16'd0 : mem_addr + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= 16'd0;
            color_code <= 3'd0;
            underflow  <= 1'b0;
            fifo_q[0]  <= 24'd0;
            fifo_q[1]  <= 24'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            index      <= 3'd0;
        end else begin
            if (frame_start) begin
                rd_ptr     <= 1'b0;
                wr_ptr     <= 1'b0;
                count      <= 2'd0;
                index      <= 3'd0;
                mem_addr   <= 16'd0;
                underflow  <= 1'b0;
                color_code <= 3'd0;
            end else begin
                if (push) begin
                    fifo_q[wr_ptr] <= mem_rdata;
                    wr_ptr         <= ~wr_ptr;
                    mem_addr       <= addr_next;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
                if (take) begin
                    color_code <= head[bit_lo +: 3];
                    index      <= index + 3'd1;
                end else begin
                    color_code <= 3'd0;
                end
                if (pixel_en && !have) begin
                    underflow <= 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (!frame_start && count < 2'd2) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (frame_start) begin
                        // Without a same-cycle ack, one stale ack is owed.
                        mem_req <= 1'b0;
                        state   <= mem_ack ? IDLE : DISCARD;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dvi_pixel_fetch.sv
// Bench for dvi_pixel_fetch: table-driven pixel stream plus hand sequences
// for underflow, stale-ack discard, async reset and address wrap.
module tb_dvi_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        pixel_en;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [23:0] mem_rdata;
    logic [2:0]  color_code;
    logic        underflow;

    logic        w_rst_n;
    logic        w_pen;
    logic        w_req;
    logic [15:0] w_addr;
    logic        w_ack;
    logic [23:0] w_rdata;
    logic [2:0]  w_color;
    logic        w_uf;
    logic        w_fs;

    dvi_pixel_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .frame_start(frame_start), .pixel_en(pixel_en),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .color_code(color_code), .underflow(underflow)
    );

    dvi_pixel_fetch #(.H_ACTIVE(16), .V_ACTIVE(2)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n),
        .frame_start(w_fs), .pixel_en(w_pen),
        .mem_req(w_req), .mem_addr(w_addr),
        .mem_ack(w_ack), .mem_rdata(w_rdata),
        .color_code(w_color), .underflow(w_uf)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [2:0] color;
        logic       uf;
    } exp_t;

    typedef struct {
        logic       pen;
        logic [2:0] color;
    } vec_t;

    exp_t        col_q [$];
    logic [15:0] addr_q [$];
    logic [15:0] w_log [$];
    vec_t        tbl [34];
    logic [15:0] wexp [6];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   acks_allowed = 0;
    int   lat = 1;
    int   wcnt = 0;
    logic force_ack = 1'b0;

    function automatic logic [23:0] data_for(input logic [15:0] a);
        return a[1] ? 24'h053977 : 24'hFAC688;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // One clock: sample outputs, pop the scoreboard, run memory models.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (col_q.size() != 0) begin
            e = col_q.pop_front();
            chk("color_code", 32'(color_code), 32'(e.color));
            chk("underflow", 32'(underflow), 32'(e.uf));
        end
        if (mem_ack) begin
            mem_ack = 1'b0;
            chk("req_low_after_ack", 32'(mem_req), 32'd0);
        end else if (force_ack) begin
            force_ack = 1'b0;
            mem_ack   = 1'b1;
            mem_rdata = 24'hFFFFFF;
        end else if (mem_req && acks_allowed > 0) begin
            if (wcnt + 1 >= lat) begin
                wcnt = 0;
                acks_allowed--;
                mem_ack   = 1'b1;
                mem_rdata = data_for(mem_addr);
                if (addr_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL req_addr: got %0h expected none",
                             mem_addr);
                end else begin
                    chk("req_addr", 32'(mem_addr),
                        32'(addr_q.pop_front()));
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        if (w_ack) begin
            w_ack = 1'b0;
        end else if (w_req) begin
            w_ack   = 1'b1;
            w_rdata = 24'hFAC688;
            w_log.push_back(w_addr);
        end
    endtask

    task automatic pix(input logic pen, input logic fs,
                       input logic [2:0] c, input logic u);
        exp_t e;
        pixel_en    = pen;
        frame_start = fs;
        e.color = c;
        e.uf    = u;
        col_q.push_back(e);
        tick();
        pixel_en    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic stream8(input logic rev);
        for (int k = 0; k < 8; k++) begin
            pix(1'b1, 1'b0, rev ? 3'(7 - k) : 3'(k), 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i]      = '{1'b1, 3'(i)};
            tbl[10 + i] = '{1'b1, 3'(i)};
            tbl[18 + i] = '{1'b1, 3'(7 - i)};
            tbl[26 + i] = '{1'b1, 3'(7 - i)};
        end
        tbl[8] = '{1'b0, 3'd0};
        tbl[9] = '{1'b0, 3'd0};
        wexp = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};

        frame_start = 1'b0;
        pixel_en    = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 24'd0;
        w_pen       = 1'b0;
        w_ack       = 1'b0;
        w_rdata     = 24'd0;
        w_fs        = 1'b0;
        w_rst_n     = 1'b0;
        rst_n       = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_color", 32'(color_code), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        tick();
        tick();
        chk("rst_req_held", 32'(mem_req), 32'd0);

        // Prefill: exactly addresses 0 and 1, then idle.
        addr_q.push_back(16'd0);
        addr_q.push_back(16'd1);
        acks_allowed = 2;
        lat = 1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("prefill_req_idle", 32'(mem_req), 32'd0);
        end
        chk("prefill_addr", 32'(mem_addr), 32'd2);

        // Steady stream from the vector table.
        for (int a = 2; a < 6; a++) addr_q.push_back(16'(a));
        acks_allowed = 4;
        for (int i = 0; i < 34; i++) begin
            pix(tbl[i].pen, 1'b0, tbl[i].color, 1'b0);
        end
        for (int i = 0; i < 6; i++) pix(1'b0, 1'b0, 3'd0, 1'b0);
        chk("stream_addrs_seen", 32'(addr_q.size()), 32'd0);
        chk("stream_addr", 32'(mem_addr), 32'd6);

        // Underflow with no acks; sticky until frame_start.
        acks_allowed = 0;
        pix(1'b0, 1'b1, 3'd0, 1'b0);
        chk("fs_addr_zero", 32'(mem_addr), 32'd0);
        pix(1'b0, 1'b0, 3'd0, 1'b0);
        chk("req_after_fs", 32'(mem_req), 32'd1);
        pix(1'b1, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            pix(1'b0, 1'b0, 3'd0, 1'b1);
            chk("req_held", 32'(mem_req), 32'd1);
            chk("req_addr_stable", 32'(mem_addr), 32'd0);
        end
        pix(1'b0, 1'b1, 3'd0, 1'b0);
        chk("req_dropped_fs", 32'(mem_req), 32'd0);
        for (int i = 0; i < 2; i++) begin
            pix(1'b0, 1'b0, 3'd0, 1'b0);
            chk("no_req_in_discard", 32'(mem_req), 32'd0);
        end
        force_ack = 1'b1;
        pix(1'b0, 1'b0, 3'd0, 1'b0);
        pix(1'b0, 1'b0, 3'd0, 1'b0);
        chk("discard_addr", 32'(mem_addr), 32'd0);

        // Stale ack on address 1 must be dropped, restart at 0.
        addr_q.push_back(16'd0);
        acks_allowed = 1;
        for (int i = 0; i < 3; i++) pix(1'b0, 1'b0, 3'd0, 1'b0);
        chk("req_a1_pending", 32'(mem_req), 32'd1);
        chk("req_a1_addr", 32'(mem_addr), 32'd1);
        pix(1'b0, 1'b1, 3'd0, 1'b0);
        chk("a1_dropped", 32'(mem_req), 32'd0);
        chk("a1_fs_addr", 32'(mem_addr), 32'd0);
        force_ack = 1'b1;
        pix(1'b0, 1'b0, 3'd0, 1'b0);
        pix(1'b0, 1'b0, 3'd0, 1'b0);
        addr_q.push_back(16'd0);
        addr_q.push_back(16'd1);
        acks_allowed = 2;
        lat = 2;
        for (int i = 0; i < 10; i++) pix(1'b0, 1'b0, 3'd0, 1'b0);
        chk("refill_seen", 32'(addr_q.size()), 32'd0);
        chk("refill_addr", 32'(mem_addr), 32'd2);

        // Ack with no request outstanding is ignored.
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) pix(1'b0, 1'b0, 3'd0, 1'b0);
        chk("stray_addr", 32'(mem_addr), 32'd2);
        chk("stray_req", 32'(mem_req), 32'd0);
        stream8(1'b0);
        stream8(1'b0);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        chk("pre_rst_addr", 32'(mem_addr), 32'd2);

        // Asynchronous reset between edges, mid-request.
        #3 rst_n = 1'b0;
        #1;
        chk("async_req", 32'(mem_req), 32'd0);
        chk("async_addr", 32'(mem_addr), 32'd0);
        chk("async_color", 32'(color_code), 32'd0);
        tick();
        addr_q.push_back(16'd0);
        addr_q.push_back(16'd1);
        acks_allowed = 2;
        lat = 3;
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) pix(1'b0, 1'b0, 3'd0, 1'b0);
        chk("post_rst_seen", 32'(addr_q.size()), 32'd0);
        chk("post_rst_addr", 32'(mem_addr), 32'd2);
        stream8(1'b0);

        // Address wrap on the small-frame instance.
        w_pen   = 1'b1;
        w_rst_n = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        chk("wrap_count", 32'(w_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < w_log.size()) begin
                chk("wrap_addr", 32'(w_log[i]), 32'(wexp[i]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
